// File: rtl/alu_pkg.sv
// Shared opcode and state encodings for the iterative ALU.
package alu_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_PASSB = 4'h0,
        OP_XOR   = 4'h1,
        OP_OR    = 4'h2,
        OP_AND   = 4'h3,
        OP_ADD   = 4'h4,
        OP_ADC   = 4'h5,
        OP_SUB   = 4'h6,
        OP_SBC   = 4'h7,
        OP_SHL   = 4'h8,
        OP_SHR   = 4'h9,
        OP_ROLC  = 4'hA,
        OP_RORC  = 4'hB,
        OP_MUL   = 4'hC,
        OP_DIVU  = 4'hD,
        OP_NOT   = 4'hE,
        OP_RSVD  = 4'hF
    } alu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        ITER = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_comb_core.sv
// Combinational datapath for every op that completes in one cycle,
// including the divide-by-zero shortcut of DIVU.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  alu_op_e          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             v
);

    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    logic [WIDTH:0]   sum;
    logic             add_v;

    // Subtraction is A + ~B + carry; the same adder serves all four arith ops.
    assign is_sub = (op == OP_SUB) || (op == OP_SBC);
    assign b_eff  = is_sub ? ~b : b;
    assign c_eff  = (op == OP_ADD) ? 1'b0 : (op == OP_SUB) ? 1'b1 : cin;
    assign sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, c_eff};
    assign add_v  = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        s    = '0;
        cout = 1'b0;
        v    = 1'b0;
        case (op)
            OP_PASSB: s = b;
            OP_XOR:   s = a ^ b;
            OP_OR:    s = a | b;
            OP_AND:   s = a & b;
            OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
                s    = sum[WIDTH-1:0];
                cout = sum[WIDTH];
                v    = add_v;
            end
            OP_SHL: begin
                s    = {a[WIDTH-2:0], 1'b0};
                cout = a[WIDTH-1];
            end
            OP_SHR: begin
                s    = {1'b0, a[WIDTH-1:1]};
                cout = a[0];
            end
            OP_ROLC: begin
                s    = {a[WIDTH-2:0], cin};
                cout = a[WIDTH-1];
            end
            OP_RORC: begin
                s    = {cin, a[WIDTH-1:1]};
                cout = a[0];
            end
            // Only reached when B==0; the top iterates otherwise.
            OP_DIVU: begin
                s    = '1;
                cout = 1'b1;
            end
            OP_NOT:  s = ~a;
            OP_RSVD: s = a;
            default: s = '0;
        endcase
    end

endmodule

// File: rtl/alu_iter.sv
// Multi-cycle ALU: single-cycle ops via alu_comb_core, MUL/DIVU iterated
// one bit per cycle, all results and flags registered.
module alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [OP_W-1:0]  I,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] H,
    output logic             Cout,
    output logic             Z,
    output logic             N,
    output logic             V
);

    // Handshake: a request is taken when start && ready at a rising edge;
    // done pulses for one cycle as S/H/flags update, and ready is already
    // high in that cycle so the next start may overlap it.

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    alu_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             is_div;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] opnd;

    alu_op_e          op;
    logic [WIDTH-1:0] core_s;
    logic             core_cout;
    logic             core_v;
    logic             multi;

    assign op    = alu_op_e'(I);
    assign multi = (op == OP_MUL) || ((op == OP_DIVU) && (B != '0));

    alu_comb_core #(.WIDTH(WIDTH)) u_core (
        .op   (op),
        .a    (A),
        .b    (B),
        .cin  (Cin),
        .s    (core_s),
        .cout (core_cout),
        .v    (core_v)
    );

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH:0]   acc_n;
    logic [WIDTH-1:0] lo_n;

    // MUL: acc:lo is the product, lo shifts out the multiplier LSB-first.
    // DIVU: acc holds the partial remainder, lo the dividend turning into the quotient.
    assign mul_sum   = lo[0] ? (acc + {1'b0, opnd}) : acc;
    assign div_shift = {acc[WIDTH-1:0], lo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd};

    always_comb begin
        acc_n = acc;
        lo_n  = lo;
        if (is_div) begin
            if (!div_diff[WIDTH]) begin
                acc_n = div_diff;
                lo_n  = {lo[WIDTH-2:0], 1'b1};
            end else begin
                acc_n = div_shift;
                lo_n  = {lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_n = {1'b0, mul_sum[WIDTH:1]};
            lo_n  = {mul_sum[0], lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            ready  <= 1'b0;
            done   <= 1'b0;
            cnt    <= '0;
            is_div <= 1'b0;
            acc    <= '0;
            lo     <= '0;
            opnd   <= '0;
            S      <= '0;
            H      <= '0;
            Cout   <= 1'b0;
            Z      <= 1'b0;
            N      <= 1'b0;
            V      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    ready <= 1'b1;
                    if (start && ready) begin
                        if (multi) begin
                            state  <= ITER;
                            ready  <= 1'b0;
                            cnt    <= '0;
                            is_div <= (op == OP_DIVU);
                            acc    <= '0;
                            lo     <= A;
                            opnd   <= B;
                        end else begin
                            S    <= core_s;
                            H    <= (op == OP_DIVU) ? A : '0;
                            Cout <= core_cout;
                            V    <= core_v;
                            Z    <= (core_s == '0);
                            N    <= core_s[WIDTH-1];
                            done <= 1'b1;
                        end
                    end
                end
                ITER: begin
                    acc <= acc_n;
                    lo  <= lo_n;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= IDLE;
                        ready <= 1'b1;
                        done  <= 1'b1;
                        S     <= lo_n;
                        H     <= acc_n[WIDTH-1:0];
                        Cout  <= is_div ? 1'b0 : (acc_n[WIDTH-1:0] != '0);
                        V     <= 1'b0;
                        Z     <= (lo_n == '0);
                        N     <= lo_n[WIDTH-1];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_iter.sv
// Directed-vector bench for alu_iter at WIDTH=8 with hand-computed results.
module tb_alu_iter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   I;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         ready;
    logic         done;
    logic [W-1:0] S;
    logic [W-1:0] H;
    logic         Cout;
    logic         Z;
    logic         N;
    logic         V;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_iter #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .I     (I),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .ready (ready),
        .done  (done),
        .S     (S),
        .H     (H),
        .Cout  (Cout),
        .Z     (Z),
        .N     (N),
        .V     (V)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_out(input string tag, input logic [W-1:0] es, input logic [W-1:0] eh,
                           input logic ec, input logic ez, input logic en, input logic ev);
        chk({tag, ".S"},    32'(S),    32'(es));
        chk({tag, ".H"},    32'(H),    32'(eh));
        chk({tag, ".Cout"}, 32'(Cout), 32'(ec));
        chk({tag, ".Z"},    32'(Z),    32'(ez));
        chk({tag, ".N"},    32'(N),    32'(en));
        chk({tag, ".V"},    32'(V),    32'(ev));
    endtask

    task automatic go(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin);
        I     = op;
        A     = a;
        B     = b;
        Cin   = cin;
        start = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        I     = 4'h0;
        A     = '0;
        B     = '0;
        Cin   = 1'b0;
        step();
        step();
        chk_out("reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.done", 32'(done), 32'd0);
        chk("reset.ready", 32'(ready), 32'd0);
        reset = 1'b0;
        step();
        chk("release.ready", 32'(ready), 32'd1);

        // ADD wraps to zero with carry
        go(4'h4, 8'hFF, 8'h01, 1'b0);
        step();
        start = 1'b0;
        chk("add.done", 32'(done), 32'd1);
        chk("add.ready", 32'(ready), 32'd1);
        chk_out("add", 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        chk("add.done_pulse", 32'(done), 32'd0);
        chk("add.hold_S", 32'(S), 32'h00);
        chk("add.hold_Cout", 32'(Cout), 32'd1);

        // SUB signed overflow, then SBC borrow, back to back
        go(4'h6, 8'h80, 8'h01, 1'b0);
        step();
        chk("sub.done", 32'(done), 32'd1);
        chk_out("sub", 8'h7F, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        go(4'h7, 8'h00, 8'h00, 1'b0);
        step();
        start = 1'b0;
        chk("sbc.done", 32'(done), 32'd1);
        chk_out("sbc", 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

        // ADC with carry-in into the sign bit
        go(4'h5, 8'h7F, 8'h00, 1'b1);
        step();
        chk_out("adc", 8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        go(4'h1, 8'hF0, 8'h3C, 1'b0);
        step();
        chk_out("xor", 8'hCC, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        go(4'h9, 8'h81, 8'h00, 1'b1);
        step();
        chk_out("shr", 8'h40, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        go(4'hE, 8'h0F, 8'h00, 1'b0);
        step();
        chk_out("not", 8'hF0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        go(4'hF, 8'h80, 8'h55, 1'b1);
        step();
        chk_out("rsvd", 8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        go(4'h0, 8'hAA, 8'h00, 1'b1);
        step();
        start = 1'b0;
        chk_out("passb", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

        // MUL 25*20 = 500 = 0x01F4, with an ignored start in cycle 4
        go(4'hC, 8'd25, 8'd20, 1'b0);
        step();
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("mul.busy_ready%0d", k), 32'(ready), 32'd0);
            chk($sformatf("mul.busy_done%0d", k), 32'(done), 32'd0);
            if (k == 4) go(4'h4, 8'h01, 8'h01, 1'b0);
            step();
            start = 1'b0;
        end
        chk("mul.done", 32'(done), 32'd1);
        chk("mul.ready", 32'(ready), 32'd1);
        chk_out("mul", 8'hF4, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        chk("mul.no_queue_done", 32'(done), 32'd0);
        chk("mul.hold_S", 32'(S), 32'hF4);

        // DIVU 200/7 = 28 rem 4
        go(4'hD, 8'd200, 8'd7, 1'b0);
        step();
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("div.busy_done%0d", k), 32'(done), 32'd0);
            step();
        end
        chk("div.done", 32'(done), 32'd1);
        chk_out("div", 8'h1C, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0);

        // Divide by zero completes in one cycle
        go(4'hD, 8'h55, 8'h00, 1'b0);
        step();
        start = 1'b0;
        chk("div0.done", 32'(done), 32'd1);
        chk_out("div0", 8'hFF, 8'h55, 1'b1, 1'b0, 1'b1, 1'b0);

        // ROLC then RORC started in the ROLC done cycle
        go(4'hA, 8'h81, 8'h00, 1'b0);
        step();
        chk("rolc.done", 32'(done), 32'd1);
        chk_out("rolc", 8'h02, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        go(4'hB, 8'h01, 8'h00, 1'b1);
        step();
        start = 1'b0;
        chk("rorc.done", 32'(done), 32'd1);
        chk_out("rorc", 8'h80, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);

        // Reset in cycle 4 of a MUL aborts it
        go(4'hC, 8'd25, 8'd20, 1'b0);
        step();
        start = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        chk_out("abort", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("abort.done", 32'(done), 32'd0);
        chk("abort.ready", 32'(ready), 32'd0);
        reset = 1'b0;
        step();
        chk("abort.ready_after", 32'(ready), 32'd1);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("abort.no_done%0d", k), 32'(done), 32'd0);
            step();
        end
        chk("abort.S_after", 32'(S), 32'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_iter.md
# alu_iter

Parametrised, multi-cycle successor to the nanoprocessor's combinational ALU. It adds a start/done handshake, registered results and flags, sign and overflow flags, shifts and rotates through carry, and iterative unsigned multiply and divide. It sits between the accumulator/RAM datapath and the control FSM, which must wait for `done` before using the result.

## Interface
- `WIDTH`, 8: operand and result width; must be ≥ 2.
- `clk`  in  1  sole clock; everything updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request; accepted only when `ready`=1.
- `I`  in  4  opcode; sampled with `start`.
- `A`  in  WIDTH  first operand (accumulator); sampled with `start`.
- `B`  in  WIDTH  second operand (RAM data); sampled with `start`.
- `Cin`  in  1  carry in; sampled with `start`.
- `ready`  out  1  idle; able to accept `start`.
- `done`  out  1  one-cycle pulse when the result registers update.
- `S`  out  WIDTH  result, or low half / quotient.
- `H`  out  WIDTH  high half of the product, or the remainder; 0 for all other ops.
- `Cout`  out  1  carry, borrow-free or shifted-out bit; divide-by-zero flag for DIVU.
- `Z`  out  1  set when `S`==0.
- `N`  out  1  `S[WIDTH-1]`.
- `V`  out  1  signed overflow for ADD, ADC, SUB and SBC; 0 for all other ops.

## Operation
Opcodes:
- 0x0 PASSB: S=B.
- 0x1 XOR, 0x2 OR, 0x3 AND: bitwise on A and B.
- 0x4 ADD: A+B.
- 0x5 ADC: A+B+Cin.
- 0x6 SUB: A+~B+1.
- 0x7 SBC: A+~B+Cin.
- For 0x4–0x7, Cout is the carry out of bit WIDTH-1. For subtraction, Cout=1 means no borrow.
- 0x8 SHL: S=A<<1, Cout=A[MSB].
- 0x9 SHR: S=A>>1 (logical), Cout=A[0].
- 0xA ROLC: S={A[W-2:0],Cin}, Cout=A[MSB].
- 0xB RORC: S={Cin,A[W-1:1]}, Cout=A[0].
- 0xC MUL: unsigned, {H,S}=A*B, Cout=(H!=0).
- 0xD DIVU: S=A/B, H=A%B, Cout=0. If B==0: S=all ones, H=A, Cout=1.
- 0xE NOT: S=~A.
- 0xF: reserved; S=A, all flags 0 except Z and N.

Flags are computed from the final `S` and written together with `S` and `H`.

FSM states:
- IDLE: `ready`=1.
  - On `start` with a single-cycle op (0x0–0xB, 0xE, 0xF), or DIVU with B==0: compute, register the result, pulse `done` in the next cycle, stay in IDLE.
  - On `start` with MUL, or DIVU with B≠0: load the operand registers, clear the iteration counter, go to ITER.
- ITER: `ready`=0.
  - One iteration per cycle: shift-add for MUL, restoring shift-subtract for DIVU.
  - The counter runs 0..WIDTH-1.
  - After the last iteration, write `S`, `H` and flags, pulse `done`, return to IDLE.
- `start` while in ITER is ignored; no queuing.
- Result registers hold their value between `done` pulses.

## Timing
- Reset: `S`, `H`, `Cout`, `Z`, `N`, `V` and `done` are 0; the FSM is in IDLE.
  - `ready`=0 while `reset` is high; `ready`=1 in the first cycle after release.
  - `Z` reads 0 during reset; it becomes valid only after the first `done`.
- Single-cycle ops: `start` in cycle t, `done` and results in cycle t+1. `ready` stays high throughout, so back-to-back starts every cycle are allowed.
- MUL and DIVU (B≠0):
  - `start` in cycle t; `ready`=0 during t+1..t+WIDTH.
  - `done` and results in cycle t+WIDTH+1.
  - `ready`=1 in the `done` cycle, so a new `start` is legal there.
- `reset` asserted mid-ITER aborts the operation: no `done`, outputs cleared per the reset values above.

## Structure
- Package `alu_pkg` contains:
  - `alu_op_e`, a 4-bit enum of the opcodes above;
  - `alu_state_e` (IDLE, ITER);
  - the constant `OP_W`=4.
- Sub-module `alu_comb_core`: a purely combinational, WIDTH-parametrised datapath for all single-cycle ops. It produces `S`, `Cout` and `V`.
- The top level holds the FSM, the iteration counter (`$clog2(WIDTH)+1` bits), the MUL/DIV shift registers and the output registers.

## Test plan
All scenarios use WIDTH=8.
- ADD: A=0xFF, B=0x01, Cin=0 → S=0x00, Cout=1, Z=1, V=0, `done` exactly 1 cycle after `start`.
- SUB: A=0x80, B=0x01 → S=0x7F, Cout=1, V=1, N=0. SBC: A=0x00, B=0x00, Cin=0 → S=0xFF, Cout=0, N=1.
- MUL: A=25, B=20 → S=0xF4, H=0x01, Cout=1.
  - `done` exactly 9 cycles after `start`; `ready`=0 for cycles 1–8.
  - A `start` in cycle 4 is ignored.
- DIVU: A=200, B=7 → S=0x1C, H=0x04, Cout=0 after 9 cycles. Divide by zero: A=0x55, B=0 → S=0xFF, H=0x55, Cout=1 after 1 cycle.
- ROLC: A=0x81, Cin=0 → S=0x02, Cout=1. Then, in the same `done` cycle, `start` RORC with A=0x01, Cin=1 → S=0x80, Cout=1 one cycle later.
- `reset` high in cycle 4 of a MUL → no `done` pulse, all outputs 0, `ready`=1 in the cycle after release.
